// File: rtl/mac_neuron_core.sv
// Single-neuron learning core: DEPTH signed Q-format weights, streamed forward
// dot product and streamed backward weight update (w += (e*x) >> LR_SHIFT).
module mac_neuron_core #(
  parameter int DW       = 16,
  parameter int FRAC     = 8,
  parameter int DEPTH    = 100,
  parameter int AW       = $clog2(DEPTH),
  parameter int LR_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_fwd,
  input  logic          start_bwd,
  input  logic [DW-1:0] e,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] x,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          vld,
  output logic          bwd_done,
  output logic [DW-1:0] y
);

  typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;

  localparam int ACCW = 2*DW + AW;
  localparam int SUMW = 2*DW + 1;
  localparam logic signed [DW-1:0]   DMAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   DMIN    = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] ACC_MAX = ACCW'(DMAX);
  localparam logic signed [ACCW-1:0] ACC_MIN = ACCW'(DMIN);
  localparam logic signed [SUMW-1:0] SUM_MAX = SUMW'(DMAX);
  localparam logic signed [SUMW-1:0] SUM_MIN = SUMW'(DMIN);

  state_t state, state_nxt;
  logic [AW-1:0] index;
  logic signed [ACCW-1:0] acc, acc_nxt, acc_shift;
  logic signed [DW-1:0] w [DEPTH];
  logic signed [DW-1:0] e_lat, w_cur, w_new, y_sat;
  logic signed [2*DW-1:0] prod, ex, delta;
  logic signed [SUMW-1:0] wsum;
  logic mode_fwd, beat, last, wr_ok;

  assign beat  = in_vld && in_rdy;
  assign last  = beat && (index == AW'(DEPTH-1));
  assign wr_ok = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign w_cur = w[index];

  // Forward path: accumulate at full width, then scale and saturate the result
  always_comb begin
    prod      = w_cur * $signed(x);
    acc_nxt   = acc + ACCW'(prod);
    acc_shift = acc_nxt >>> FRAC;
    if (acc_shift > ACC_MAX)      y_sat = DMAX;
    else if (acc_shift < ACC_MIN) y_sat = DMIN;
    else                          y_sat = acc_shift[DW-1:0];
  end

  // Backward path: the sum is kept wide enough that a large delta cannot wrap
  always_comb begin
    ex    = e_lat * $signed(x);
    delta = ex >>> (FRAC + LR_SHIFT);
    wsum  = SUMW'(w_cur) + SUMW'(delta);
    if (wsum > SUM_MAX)      w_new = DMAX;
    else if (wsum < SUM_MIN) w_new = DMIN;
    else                     w_new = wsum[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_fwd)      state_nxt = FWD;
        else if (start_bwd) state_nxt = BWD;
      end
      FWD:  if (last) state_nxt = DONE;
      BWD:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = (state == FWD) || (state == BWD);
    busy     = (state != IDLE);
    vld      = (state == DONE) && mode_fwd;
    bwd_done = (state == DONE) && !mode_fwd;
  end

  // y is loaded on the final forward beat so it is valid alongside vld in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index    <= '0;
      acc      <= '0;
      e_lat    <= '0;
      mode_fwd <= 1'b0;
      y        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fwd) begin
            acc      <= '0;
            index    <= '0;
            mode_fwd <= 1'b1;
          end else if (start_bwd) begin
            index    <= '0;
            e_lat    <= $signed(e);
            mode_fwd <= 1'b0;
          end
        end
        FWD: if (beat) begin
          acc   <= acc_nxt;
          index <= index + AW'(1);
          if (last) y <= y_sat;
        end
        BWD: if (beat) index <= index + AW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) w[i] <= '0;
    end else if (state == IDLE) begin
      if (wr_en && wr_ok) w[wr_addr] <= $signed(wr_data);
    end else if (state == BWD && beat) begin
      w[index] <= w_new;
    end
  end

endmodule

// File: tb/tb_mac_neuron_core.sv
// Directed bench for mac_neuron_core (DEPTH=4): a weight model predicts each
// forward result, which is queued at start and compared when vld appears.
module tb_mac_neuron_core;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic clk, rst, start_fwd, start_bwd, in_vld, in_rdy, wr_en;
  logic busy, vld, bwd_done;
  logic [DW-1:0] e, x, wr_data, y;
  logic [AW-1:0] wr_addr;

  int passed = 0;
  int total = 0;
  longint mw [DEPTH];
  longint model_y = 0;
  longint exp_y_q [$];
  int exp_lat_q [$];
  int xv [DEPTH];

  mac_neuron_core #(.DW(DW), .FRAC(8), .DEPTH(DEPTH), .AW(AW), .LR_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .start_fwd(start_fwd), .start_bwd(start_bwd), .e(e),
    .in_vld(in_vld), .in_rdy(in_rdy), .x(x), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .vld(vld), .bwd_done(bwd_done), .y(y)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic write_w(input int a, input longint d);
    wr_en = 1; wr_addr = AW'(a); wr_data = DW'(d);
    @(negedge clk);
    wr_en = 0;
    mw[a] = d;
  endtask

  task automatic write_all(input longint d);
    for (int i = 0; i < DEPTH; i++) write_w(i, d);
  endtask

  // Drives one forward pass; optionally with both starts, a gap, or a write during the pass
  task automatic applyStimulus(input int xs[DEPTH], input int gap_at, input int gap_len,
                               input bit both, input bit wr_during);
    longint s = 0;
    int cnt, bi, g, lat;
    longint ey;
    for (int i = 0; i < DEPTH; i++) s += mw[i] * longint'(xs[i]);
    exp_y_q.push_back(sat(s >>> 8));
    exp_lat_q.push_back(DEPTH + 1 + gap_len);
    check("rdy_idle", longint'(in_rdy), 0);
    start_fwd = 1; start_bwd = both; e = 16'sd256;
    @(negedge clk);
    start_fwd = 0; start_bwd = 0;
    cnt = 1; bi = 0; g = 0;
    while (!vld && cnt < 40) begin
      wr_en = wr_during; wr_addr = 1; wr_data = 16'd999;
      if (bi < DEPTH && bi == gap_at && g < gap_len && in_rdy) begin
        in_vld = 0; g++;
      end else if (bi < DEPTH) begin
        in_vld = 1; x = DW'(xs[bi]);
        if (in_rdy) bi++;
      end else in_vld = 0;
      @(negedge clk);
      cnt++;
    end
    in_vld = 0; wr_en = 0;
    checkOutput(cnt);
  endtask

  task automatic checkOutput(input int cnt);
    longint ey;
    int lat;
    ey = exp_y_q.pop_front();
    lat = exp_lat_q.pop_front();
    check("vld_seen", longint'(vld), 1);
    check("vld_latency", cnt, lat);
    check("y", longint'($signed(y)), ey);
    model_y = ey;
    @(negedge clk);
    check("vld_pulse", longint'(vld), 0);
    check("busy_after", longint'(busy), 0);
  endtask

  task automatic run_bwd(input longint ev, input int xs[DEPTH]);
    int cnt, bi;
    for (int i = 0; i < DEPTH; i++) mw[i] = sat(mw[i] + ((ev * longint'(xs[i])) >>> 12));
    start_bwd = 1; e = DW'(ev);
    @(negedge clk);
    start_bwd = 0; e = 0;
    cnt = 1; bi = 0;
    while (!bwd_done && cnt < 40) begin
      if (bi < DEPTH) begin
        in_vld = 1; x = DW'(xs[bi]);
        if (in_rdy) bi++;
      end else in_vld = 0;
      @(negedge clk);
      cnt++;
    end
    in_vld = 0;
    check("bwd_done", longint'(bwd_done), 1);
    check("bwd_latency", cnt, DEPTH + 1);
    check("bwd_vld", longint'(vld), 0);
    check("bwd_y_held", longint'($signed(y)), model_y);
    @(negedge clk);
    check("bwd_pulse", longint'(bwd_done), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < DEPTH; i++) mw[i] = 0;
    model_y = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int vcount;
    rst = 1; start_fwd = 0; start_bwd = 0; e = 0; in_vld = 0; x = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    do_reset();
    check("rst_busy", longint'(busy), 0);
    check("rst_y", longint'($signed(y)), 0);
    check("rst_vld", longint'(vld), 0);
    check("rst_bwd_done", longint'(bwd_done), 0);
    check("rst_rdy", longint'(in_rdy), 0);

    $display("[TB] case 1: unit weights, ramp inputs");
    write_all(256);
    xv = '{256, 512, 768, 1024};
    applyStimulus(xv, -1, 0, 0, 0);

    $display("[TB] case 2: saturation");
    write_all(32767);
    xv = '{32767, 32767, 32767, 32767};
    applyStimulus(xv, -1, 0, 0, 0);
    write_all(-32768);
    applyStimulus(xv, -1, 0, 0, 0);

    $display("[TB] case 3: backward from zero weights");
    do_reset();
    xv = '{256, 256, 256, 256};
    run_bwd(256, xv);
    applyStimulus(xv, -1, 0, 0, 0);
    xv = '{1, 1, 1, 1};
    run_bwd(-256, xv);
    xv = '{256, 256, 256, 256};
    applyStimulus(xv, -1, 0, 0, 0);

    $display("[TB] case 4: input gap");
    write_all(256);
    xv = '{256, 512, 768, 1024};
    applyStimulus(xv, 2, 3, 0, 0);

    $display("[TB] case 5: reset mid-pass");
    start_fwd = 1;
    @(negedge clk);
    start_fwd = 0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1; x = DW'(xv[i]);
      @(negedge clk);
    end
    in_vld = 0;
    rst = 1;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_y", longint'($signed(y)), 0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst = 0;
      @(negedge clk);
      if (vld) vcount++;
    end
    check("abort_no_vld", vcount, 0);
    for (int i = 0; i < DEPTH; i++) mw[i] = 0;
    model_y = 0;
    write_all(256);
    applyStimulus(xv, -1, 0, 0, 0);

    $display("[TB] case 6: both starts and write during FWD");
    write_w(0, 100); write_w(1, -300); write_w(2, 50); write_w(3, 7);
    xv = '{256, 256, 256, 256};
    applyStimulus(xv, -1, 0, 1, 1);
    xv = '{0, 256, 0, 0};
    applyStimulus(xv, -1, 0, 0, 0);
    xv = '{256, 0, 0, 0};
    applyStimulus(xv, -1, 0, 0, 0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
